ysyx22041405_regfile_sb: RTL and testbench
==========================================

# ysyx22041405_regfile_sb

Parametrised multi-read-port integer register file with two write ports, same-cycle write-to-read bypass and an integrated per-register busy scoreboard. It sits in the IDU: decode reads operands and busy flags here, issue marks destinations busy, and the writeback and late-load paths write results and release the busy flags. A registered debug read port and a busy-register counter feed the difftest/trace side.

## Interface
- WIDTH, 32: data width of each register
- NREG, 32: number of registers; power of two, ≥ 2; AW = $clog2(NREG)
- NR, 2: number of combinational read ports, ≥ 1
- CW: derived, $clog2(NREG+1); width of busy_cnt
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NR*AW  read addresses; port k at [k*AW +: AW]
- rd_data  out  NR*WIDTH  read data; port k at [k*WIDTH +: WIDTH]
- rd_busy  out  NR  busy flag of the addressed register, per port
- we0 / waddr0 / wdata0  in  1 / AW / WIDTH  write port 0 (writeback)
- we1 / waddr1 / wdata1  in  1 / AW / WIDTH  write port 1 (late load); higher priority
- iss_valid / iss_addr  in  1 / AW  issue: mark iss_addr busy
- flush  in  1  synchronous clear of all busy flags
- dbg_addr  in  AW  debug read address
- dbg_data  out  WIDTH  registered debug read data
- busy_cnt  out  CW  number of registers currently busy

## Operation
- State: rf[NREG] of WIDTH bits, busy[NREG] bits, dbg_data register, busy_cnt register.
- Register 0: reads always 0; writes, issues and busy marking to address 0 are ignored; busy[0] is always 0.
- Write: a port with weN=1 and waddrN≠0 writes rf[waddrN] at the edge. Both ports to the same nonzero address: port 1 data is stored.
- Read (combinational, per port k): addr 0 → 0; else if we1 && waddr1==addr → wdata1; else if we0 && waddr0==addr → wdata0; else rf[addr].
- Busy next state per register r≠0, in priority order:
  - flush=1 → 0 (overrides everything, including a same-cycle issue);
  - iss_valid && iss_addr==r → 1 (the new producer wins over a same-cycle write to r);
  - any valid write to r → 0;
  - otherwise hold.
- rd_busy[k] = busy[addr] & ~(a valid write to addr this cycle); addr 0 → 0. A same-cycle issue does not affect rd_busy.
- Debug: dbg_data <= bypassed value of dbg_addr using the same priority as the read ports (port 1, port 0, array; addr 0 → 0).
- busy_cnt <= population count of the busy next state; it always equals the number of set busy bits after each edge.

## Timing
- Reset (asynchronous assert, released synchronously by the system): rf all 0, busy all 0, dbg_data 0, busy_cnt 0. rd_data and rd_busy are 0 while rst is high, regardless of address.
- Reset asserted mid-operation overrides any write, issue or flush in that cycle.
- Read, bypass and rd_busy: combinational, 0-cycle latency.
- Write becomes visible in the array from the next cycle; it is visible through the bypass in the same cycle.
- Issue at cycle t: busy set and rd_busy=1 from t+1.
- Write at cycle t: rd_busy=0 already in cycle t; busy cleared from t+1.
- dbg_data and busy_cnt: 1-cycle latency.
- No handshakes: every input is sampled every cycle; nothing stalls.

## Test plan
- Reset, then write x5=0xDEADBEEF via port 0, read x5 on port 0 and port 1 in the next cycle → both return 0xDEADBEEF; the write cycle itself returns 0xDEADBEEF via bypass.
- Both ports write x7 (port 0 0x11, port 1 0x22) in the same cycle → bypass reads 0x22, and 0x22 is stored; a write of 0x55 to x0 → x0 still reads 0.
- Issue x3 at t → rd_busy=1 and busy_cnt=1 at t+1; write x3 at t+2 → rd_busy=0 at t+2, busy_cnt=0 at t+3.
- Same cycle: issue x4 and write x4=0x9 → rd_busy=1 and rd_data=0x9 in the next cycle; issue x4 together with flush → busy_cnt=0.
- Issue x1..x31 over 31 cycles → busy_cnt=31 (NREG=32); flush → busy_cnt=0 one cycle later.
- Assert rst asynchronously between edges while x9 is written and busy → rd_data for x9, rd_busy, dbg_data and busy_cnt all read 0 immediately.

Source files
------------

// File: rtl/ysyx22041405_regfile_sb.sv
// Integer register file with two write ports, same-cycle bypass and a per-register
// busy scoreboard; registered debug read port and busy-register counter.
`default_nettype none

module ysyx22041405_regfile_sb #(
    parameter  int WIDTH = 32,
    parameter  int NREG  = 32,
    parameter  int NR    = 2,
    localparam int AW    = $clog2(NREG),
    localparam int CW    = $clog2(NREG + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NR*AW-1:0]    rd_addr_i,
    output logic [NR*WIDTH-1:0] rd_data_o,
    output logic [NR-1:0]       rd_busy_o,
    input  logic                we0_i,
    input  logic [AW-1:0]       waddr0_i,
    input  logic [WIDTH-1:0]    wdata0_i,
    input  logic                we1_i,
    input  logic [AW-1:0]       waddr1_i,
    input  logic [WIDTH-1:0]    wdata1_i,
    input  logic                iss_valid_i,
    input  logic [AW-1:0]       iss_addr_i,
    input  logic                flush_i,
    input  logic [AW-1:0]       dbg_addr_i,
    output logic [WIDTH-1:0]    dbg_data_o,
    output logic [CW-1:0]       busy_cnt_o
);

    logic [WIDTH-1:0] rf_q [NREG];
    logic [NREG-1:0]  busy_q, busy_d;
    logic [WIDTH-1:0] dbg_q, dbg_d;
    logic [CW-1:0]    busy_cnt_q, busy_cnt_d;

    // Writes to x0 are squashed here so every consumer sees a single "valid write" notion.
    logic wr0_valid, wr1_valid;
    assign wr0_valid = we0_i && (waddr0_i != '0);
    assign wr1_valid = we1_i && (waddr1_i != '0);

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit0, hit1;
        assign addr = rd_addr_i[k*AW +: AW];
        assign hit1 = wr1_valid && (waddr1_i == addr);
        assign hit0 = wr0_valid && (waddr0_i == addr);

        assign rd_data_o[k*WIDTH +: WIDTH] = (rst || addr == '0) ? '0 :
                                             hit1 ? wdata1_i :
                                             hit0 ? wdata0_i : rf_q[addr];
        assign rd_busy_o[k] = !rst && (addr != '0) && busy_q[addr] && !hit0 && !hit1;
    end

    always_comb begin
        dbg_d = rf_q[dbg_addr_i];
        if (dbg_addr_i == '0) begin
            dbg_d = '0;
        end else if (wr1_valid && waddr1_i == dbg_addr_i) begin
            dbg_d = wdata1_i;
        end else if (wr0_valid && waddr0_i == dbg_addr_i) begin
            dbg_d = wdata0_i;
        end
    end

    // Flush beats issue, and a new producer beats a same-cycle write-back.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (flush_i) begin
                busy_d[r] = 1'b0;
            end else if (iss_valid_i && iss_addr_i == AW'(r)) begin
                busy_d[r] = 1'b1;
            end else if ((wr1_valid && waddr1_i == AW'(r)) ||
                         (wr0_valid && waddr0_i == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_cnt_d = busy_cnt_d + CW'(busy_d[r]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                rf_q[r] <= '0;
            end
            busy_q     <= '0;
            dbg_q      <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (wr1_valid && waddr1_i == AW'(r)) begin
                    rf_q[r] <= wdata1_i;
                end else if (wr0_valid && waddr0_i == AW'(r)) begin
                    rf_q[r] <= wdata0_i;
                end
            end
            busy_q     <= busy_d;
            dbg_q      <= dbg_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign dbg_data_o = dbg_q;
    assign busy_cnt_o = busy_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx22041405_regfile_sb.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against an array-based model of the register file.
`default_nettype none

module tb_ysyx22041405_regfile_sb;

    localparam int WIDTH = 32;
    localparam int NREG  = 32;
    localparam int NR    = 2;
    localparam int AW    = 5;
    localparam int CW    = 6;

    logic                clk;
    logic                rst;
    logic [NR*AW-1:0]    rd_addr;
    logic [NR*WIDTH-1:0] rd_data;
    logic [NR-1:0]       rd_busy;
    logic                we0, we1, iss_valid, flush;
    logic [AW-1:0]       waddr0, waddr1, iss_addr, dbg_addr;
    logic [WIDTH-1:0]    wdata0, wdata1, dbg_data;
    logic [CW-1:0]       busy_cnt;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    ysyx22041405_regfile_sb #(.WIDTH(WIDTH), .NREG(NREG), .NR(NR)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_busy_o   (rd_busy),
        .we0_i       (we0),
        .waddr0_i    (waddr0),
        .wdata0_i    (wdata0),
        .we1_i       (we1),
        .waddr1_i    (waddr1),
        .wdata1_i    (wdata1),
        .iss_valid_i (iss_valid),
        .iss_addr_i  (iss_addr),
        .flush_i     (flush),
        .dbg_addr_i  (dbg_addr),
        .dbg_data_o  (dbg_data),
        .busy_cnt_o  (busy_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] m_rf [NREG];
    bit               m_busy [NREG];
    logic [WIDTH-1:0] m_dbg;
    int               m_cnt;

    function automatic bit m_wr(input logic [AW-1:0] a);
        return a != 0 && ((we0 && waddr0 == a) || (we1 && waddr1 == a));
    endfunction

    function automatic logic [WIDTH-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we1 && waddr1 == a) return wdata1;
        if (we0 && waddr0 == a) return wdata0;
        return m_rf[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_rf[r] = '0;
                m_busy[r] = 0;
            end
            m_dbg = '0;
            m_cnt = 0;
        end else begin
            bit nb [NREG];
            m_dbg = m_read(dbg_addr);
            for (int r = 1; r < NREG; r++) begin
                if (flush) nb[r] = 0;
                else if (iss_valid && iss_addr == r) nb[r] = 1;
                else if (m_wr(AW'(r))) nb[r] = 0;
                else nb[r] = m_busy[r];
            end
            if (we0 && waddr0 != 0) m_rf[waddr0] = wdata0;
            if (we1 && waddr1 != 0) m_rf[waddr1] = wdata1;
            m_cnt = 0;
            for (int r = 1; r < NREG; r++) begin
                m_busy[r] = nb[r];
                m_cnt += int'(nb[r]);
            end
        end
    end

    // Compare process: combinational outputs against model + live inputs, registered ones against model state.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NR; k++) begin
                logic [AW-1:0] a;
                a = rd_addr[k*AW +: AW];
                chk($sformatf("rd_data[%0d]", k), rd_data[k*WIDTH +: WIDTH],
                    rst ? '0 : m_read(a));
                chk($sformatf("rd_busy[%0d]", k), rd_busy[k],
                    (!rst && a != 0 && m_busy[a] && !m_wr(a)) ? 1 : 0);
            end
            chk("dbg_data", dbg_data, m_dbg);
            chk("busy_cnt", busy_cnt, m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        we0 = 0; we1 = 0; iss_valid = 0; flush = 0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; iss_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
        return AW'($urandom_range(0, 5));
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        rd_addr = '0;
        dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;

        // Reset state and write/bypass of x5
        set_rd(5, 5);
        #1 chk("reset x5", rd_data[31:0], 32'h0);
        chk("reset cnt", busy_cnt, 0);
        we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
        #1 chk("x5 bypass p0", rd_data[31:0], 32'hDEADBEEF);
        chk("x5 bypass p1", rd_data[63:32], 32'hDEADBEEF);
        tick(); idle();
        #1 chk("x5 array p0", rd_data[31:0], 32'hDEADBEEF);
        chk("x5 array p1", rd_data[63:32], 32'hDEADBEEF);

        // Dual write to x7: port 1 wins; write to x0 ignored
        tick();
        we0 = 1; waddr0 = 7; wdata0 = 32'h11;
        we1 = 1; waddr1 = 7; wdata1 = 32'h22;
        set_rd(7, 0);
        #1 chk("x7 bypass", rd_data[31:0], 32'h22);
        tick(); idle();
        we0 = 1; waddr0 = 0; wdata0 = 32'h55;
        #1 chk("x0 bypass", rd_data[63:32], 32'h0);
        chk("x7 stored", rd_data[31:0], 32'h22);
        tick(); idle();
        #1 chk("x0 stored", rd_data[63:32], 32'h0);

        // Issue x3, release by write two cycles later
        tick();
        iss_valid = 1; iss_addr = 3;
        set_rd(3, 0);
        tick(); idle();
        #1 chk("x3 busy", rd_busy[0], 1);
        chk("cnt after iss x3", busy_cnt, 1);
        tick();
        we0 = 1; waddr0 = 3; wdata0 = 32'h33;
        #1 chk("x3 busy during wr", rd_busy[0], 0);
        tick(); idle();
        #1 chk("cnt after wr x3", busy_cnt, 0);

        // Issue + write to x4 in the same cycle; then issue + flush
        iss_valid = 1; iss_addr = 4;
        we0 = 1; waddr0 = 4; wdata0 = 32'h9;
        set_rd(4, 0);
        tick(); idle();
        #1 chk("x4 busy", rd_busy[0], 1);
        chk("x4 data", rd_data[31:0], 32'h9);
        iss_valid = 1; iss_addr = 4; flush = 1;
        tick(); idle();
        #1 chk("cnt after flush+iss", busy_cnt, 0);

        // Fill the scoreboard, then flush
        for (int r = 1; r < NREG; r++) begin
            iss_valid = 1; iss_addr = AW'(r);
            tick();
        end
        idle();
        #1 chk("cnt full", busy_cnt, 31);
        flush = 1;
        tick(); idle();
        #1 chk("cnt after flush", busy_cnt, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            tick();
            we0 = 1'($urandom); waddr0 = rnd_addr(); wdata0 = $urandom;
            we1 = ($urandom_range(0, 2) == 0); waddr1 = rnd_addr(); wdata1 = $urandom;
            iss_valid = 1'($urandom); iss_addr = rnd_addr();
            flush = ($urandom_range(0, 15) == 0);
            set_rd(rnd_addr(), rnd_addr());
            dbg_addr = rnd_addr();
        end

        // Asynchronous reset mid-cycle while x9 is written and x10 is busy
        tick(); idle();
        we0 = 1; waddr0 = 9; wdata0 = 32'h1234;
        tick(); idle();
        iss_valid = 1; iss_addr = 9;
        tick(); idle();
        iss_valid = 1; iss_addr = 10;
        dbg_addr = 9;
        tick(); idle();
        we0 = 1; waddr0 = 9; wdata0 = 32'h5678;
        set_rd(9, 10);
        #1 chk("pre-rst x10 busy", rd_busy[1], 1);
        chk("pre-rst dbg", dbg_data, 32'h1234);
        rst = 1'b1;
        #1 chk("rst x9 data", rd_data[31:0], 32'h0);
        chk("rst busy p1", rd_busy[1], 0);
        chk("rst dbg", dbg_data, 32'h0);
        chk("rst cnt", busy_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle();
        #1 chk("post-rst x9", rd_data[31:0], 32'h0);
        chk("post-rst x10 busy", rd_busy[1], 0);
        tick();
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
